// File: rtl/imem_dmem_loader.sv
// imem_dmem_loader: word-array memory responder for the multicycle core.
// One array serves the instruction-fetch port (read-only) and the data port
// (read/write). A byte-serial loader fills the array from word 0 while the
// core is held in reset; core_run releases it.
//
// Loader handshake: a byte transfers on a rising edge where
// load_valid & load_ready are both high; load_ready is high exactly in LOAD,
// load_valid may be raised or dropped at any time, and load_byte/load_last are
// only looked at on a transfer edge. A load_start on the same edge restarts
// the load and that byte is discarded.
module imem_dmem_loader #(
   parameter int WORD_LEN   = 32,
   parameter int DEPTH_LOG2 = 12
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [WORD_LEN-1:0] addr_i,
   output logic [WORD_LEN-1:0] inst,
   input  logic [WORD_LEN-1:0] addr_d,
   output logic [WORD_LEN-1:0] rdata,
   input  logic                wen,
   input  logic [WORD_LEN-1:0] wdata,
   input  logic                load_start,
   input  logic                run_start,
   input  logic                load_valid,
   output logic                load_ready,
   input  logic [7:0]          load_byte,
   input  logic                load_last,
   output logic                core_run,
   output logic                load_err,
   output logic [1:0]          dbg_state
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] PTR_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2
   } state_t;

   state_t state, state_next;

   // Storage is deliberately not reset: a program survives a reset.
   logic [WORD_LEN-1:0] mem [DEPTH];

   // Loader state. ptr has one extra bit so it stops at DEPTH instead of wrapping.
   logic [DEPTH_LOG2:0] ptr;
   logic [1:0]          bcnt;
   logic [WORD_LEN-1:0] asm_q;
   logic [WORD_LEN-1:0] asm_next;

   logic byte_acc;
   logic word_done;
   logic ptr_full;
   logic ld_we;
   logic core_we;

   logic                  mem_we;
   logic [DEPTH_LOG2-1:0] mem_waddr;
   logic [WORD_LEN-1:0]   mem_wdata;

   // Address decode: word index from bits [DEPTH_LOG2+1:2], anything set
   // above that is out of range. Bits [1:0] carry no meaning (no byte lanes).
   logic                  oor_i, oor_d;
   logic [DEPTH_LOG2-1:0] idx_i, idx_d;
   logic                  unused_low_bits;

   assign oor_i = |addr_i[WORD_LEN-1:DEPTH_LOG2+2];
   assign oor_d = |addr_d[WORD_LEN-1:DEPTH_LOG2+2];
   assign idx_i = addr_i[DEPTH_LOG2+1:2];
   assign idx_d = addr_d[DEPTH_LOG2+1:2];
   assign unused_low_bits = ^{addr_i[1:0], addr_d[1:0]};

   // Asynchronous read ports; out-of-range reads return zero.
   assign inst  = oor_i ? '0 : mem[idx_i];
   assign rdata = oor_d ? '0 : mem[idx_d];

   assign load_ready = (state == ST_LOAD);
   assign dbg_state  = state;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_next;
   end

   // Next-state: load_start enters (or restarts) LOAD from any state and
   // beats run_start; the accepted last byte hands over to RUN.
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: begin
            if (load_start)     state_next = ST_LOAD;
            else if (run_start) state_next = ST_RUN;
         end
         ST_LOAD: begin
            if (load_start)                 state_next = ST_LOAD;
            else if (byte_acc && load_last) state_next = ST_RUN;
         end
         ST_RUN: begin
            if (load_start) state_next = ST_LOAD;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // core_run is registered from the next state so it changes on the same
   // edge as the state and never glitches into the core's reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) core_run <= 1'b0;
      else        core_run <= (state_next == ST_RUN);
   end

   // Byte assembly: little-endian placement, word written on the 4th byte or
   // on load_last (upper bytes already zero because asm_q clears per word).
   always_comb begin
      byte_acc  = load_valid && load_ready && !load_start;
      asm_next  = asm_q | (WORD_LEN'(load_byte) << {bcnt, 3'b000});
      word_done = byte_acc && ((bcnt == 2'd3) || load_last);
      ptr_full  = ptr[DEPTH_LOG2];
      ld_we     = word_done && !ptr_full;
      core_we   = wen && (state == ST_RUN) && !oor_d;
   end

   // Write-port mux: loader writes only happen in LOAD and core writes only
   // in RUN, so the two sources never collide.
   always_comb begin
      mem_we    = 1'b0;
      mem_waddr = '0;
      mem_wdata = '0;
      if (ld_we) begin
         mem_we    = 1'b1;
         mem_waddr = ptr[DEPTH_LOG2-1:0];
         mem_wdata = asm_next;
      end else if (core_we) begin
         mem_we    = 1'b1;
         mem_waddr = idx_d;
         mem_wdata = wdata;
      end
   end

   // Array write; no reset on purpose.
   always_ff @(posedge clk) begin
      if (mem_we) mem[mem_waddr] <= mem_wdata;
   end

   // Loader registers: cleared on reset and on every entry into LOAD.
   // Past the end of the array words are dropped and load_err latches, but
   // bytes keep being accepted so the stream can drain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr      <= '0;
         bcnt     <= 2'd0;
         asm_q    <= '0;
         load_err <= 1'b0;
      end else if (load_start) begin
         ptr      <= '0;
         bcnt     <= 2'd0;
         asm_q    <= '0;
         load_err <= 1'b0;
      end else if (byte_acc) begin
         if (word_done) begin
            bcnt  <= 2'd0;
            asm_q <= '0;
            if (ptr_full) load_err <= 1'b1;
            else          ptr      <= ptr + PTR_ONE;
         end else begin
            bcnt  <= bcnt + 2'd1;
            asm_q <= asm_next;
         end
      end
   end

endmodule

// File: tb/tb_imem_dmem_loader.sv
// Testbench for imem_dmem_loader: a full-size instance plus a 4-word instance
// sharing the same stimulus, so the small one exercises overflow.
module tb_imem_dmem_loader;

   localparam int W = 32;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [W-1:0] addr_i = '0, addr_d = '0, wdata = '0;
   logic         wen = 1'b0, load_start = 1'b0, run_start = 1'b0;
   logic         load_valid = 1'b0, load_last = 1'b0;
   logic [7:0]   load_byte = '0;

   logic [W-1:0] inst, rdata, inst2, rdata2;
   logic         load_ready, core_run, load_err;
   logic         load_ready2, core_run2, load_err2;
   logic [1:0]   dbg_state, unused_state2;

   imem_dmem_loader #(.WORD_LEN(W), .DEPTH_LOG2(12)) dut (
      .clk(clk), .rst_n(rst_n), .addr_i(addr_i), .inst(inst),
      .addr_d(addr_d), .rdata(rdata), .wen(wen), .wdata(wdata),
      .load_start(load_start), .run_start(run_start),
      .load_valid(load_valid), .load_ready(load_ready),
      .load_byte(load_byte), .load_last(load_last),
      .core_run(core_run), .load_err(load_err), .dbg_state(dbg_state)
   );

   imem_dmem_loader #(.WORD_LEN(W), .DEPTH_LOG2(2)) dut_small (
      .clk(clk), .rst_n(rst_n), .addr_i(addr_i), .inst(inst2),
      .addr_d(addr_d), .rdata(rdata2), .wen(wen), .wdata(wdata),
      .load_start(load_start), .run_start(run_start),
      .load_valid(load_valid), .load_ready(load_ready2),
      .load_byte(load_byte), .load_last(load_last),
      .core_run(core_run2), .load_err(load_err2), .dbg_state(unused_state2)
   );

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_pass   = 0;
   logic [W-1:0] exp_q[$];
   logic [W-1:0] exp_a[$];
   logic [W-1:0] tb_acc = '0;
   int           tb_k = 0;
   int           tb_ptr = 0;

   task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   // ---------------- driver tasks ----------------
   task automatic pulse_load();
      load_start = 1'b1;
      @(negedge clk);
      load_start = 1'b0;
      tb_acc = '0;
      tb_k   = 0;
      tb_ptr = 0;
   endtask

   task automatic pulse_run();
      run_start = 1'b1;
      @(negedge clk);
      run_start = 1'b0;
   endtask

   // One byte in one cycle; the expected word is queued once it is complete.
   task automatic send_byte(input logic [7:0] b, input logic last);
      load_valid = 1'b1;
      load_byte  = b;
      load_last  = last;
      @(negedge clk);
      load_valid = 1'b0;
      load_last  = 1'b0;
      tb_acc = tb_acc | (W'(b) << (8 * tb_k));
      tb_k++;
      if (tb_k == 4 || last) begin
         exp_a.push_back(W'(tb_ptr * 4));
         exp_q.push_back(tb_acc);
         tb_ptr++;
         tb_acc = '0;
         tb_k   = 0;
      end
   endtask

   task automatic core_write(input logic [W-1:0] a, input logic [W-1:0] d);
      addr_d = a;
      wdata  = d;
      wen    = 1'b1;
      @(negedge clk);
      wen    = 1'b0;
   endtask

   task automatic async_reset();
      #2 rst_n = 1'b0;
      #1;
      check("rst_core_run", {31'b0, core_run}, 32'd0);
      check("rst_load_ready", {31'b0, load_ready}, 32'd0);
      check("rst_load_err", {31'b0, load_err}, 32'd0);
      check("rst_state", {30'b0, dbg_state}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Pop every queued word and compare it through both read ports.
   task automatic drain(input string tag);
      logic [W-1:0] a, e;
      while (exp_q.size() > 0) begin
         a = exp_a.pop_front();
         e = exp_q.pop_front();
         addr_i = a;
         addr_d = a;
         #1;
         check($sformatf("%s_inst_%0h", tag, a), inst, e);
         check($sformatf("%s_rdata_%0h", tag, a), rdata, e);
         if (a < 16) check($sformatf("%s_small_inst_%0h", tag, a), inst2, e);
      end
      @(negedge clk);
   endtask

   task automatic read_check(input string tag, input logic [W-1:0] a, input logic [W-1:0] e);
      addr_i = a;
      addr_d = a;
      #1;
      check({tag, "_inst"}, inst, e);
      check({tag, "_rdata"}, rdata, e);
   endtask

   // ---------------- stimulus ----------------
   logic [7:0]   prog [8];
   logic [W-1:0] w0;

   initial begin
      prog = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};

      // Reset values
      #3;
      check("reset_core_run", {31'b0, core_run}, 32'd0);
      check("reset_load_ready", {31'b0, load_ready}, 32'd0);
      check("reset_load_err", {31'b0, load_err}, 32'd0);
      check("reset_state", {30'b0, dbg_state}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Aligned two-word load
      pulse_load();
      check("load_ready_after_start", {31'b0, load_ready}, 32'd1);
      check("state_load", {30'b0, dbg_state}, 32'd1);
      for (int i = 0; i < 8; i++) send_byte(prog[i], i == 7);
      check("aligned_core_run", {31'b0, core_run}, 32'd1);
      check("aligned_load_ready", {31'b0, load_ready}, 32'd0);
      check("state_run", {30'b0, dbg_state}, 32'd2);
      drain("aligned");
      read_check("aligned_addr4", 32'h4, 32'h0010_0093);

      // Partial word with gaps; restart from RUN
      pulse_load();
      check("restart_core_run", {31'b0, core_run}, 32'd0);
      send_byte(8'hAA, 1'b0);
      @(negedge clk);
      send_byte(8'hBB, 1'b0);
      repeat (2) @(negedge clk);
      send_byte(8'hCC, 1'b1);
      check("partial_core_run", {31'b0, core_run}, 32'd1);
      drain("partial");
      read_check("partial_word1_kept", 32'h4, 32'h0010_0093);

      // Random bytes with random valid gaps
      pulse_load();
      for (int i = 0; i < 14; i++) begin
         send_byte(8'($urandom_range(0, 255)), i == 13);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      w0 = exp_q[0];
      drain("random");

      // Core data access in RUN
      core_write(32'h100, 32'hDEAD_BEEF);
      read_check("core_wr_100", 32'h100, 32'hDEAD_BEEF);
      read_check("core_wr_102", 32'h102, 32'hDEAD_BEEF);
      @(negedge clk);
      core_write(32'h1_0000, 32'h1234_5678);
      read_check("oor_read", 32'h1_0000, 32'h0);
      read_check("oor_write_dropped", 32'h0, w0);
      @(negedge clk);

      // Core write during LOAD is ignored
      pulse_load();
      core_write(32'h100, 32'h1111_1111);
      for (int i = 0; i < 4; i++) send_byte(8'(i + 1), i == 3);
      drain("load4");
      read_check("wen_in_load_ignored", 32'h100, 32'hDEAD_BEEF);
      @(negedge clk);

      // 20-byte stream: the 4-word instance overflows
      pulse_load();
      for (int i = 0; i < 20; i++) send_byte(8'(i + 1), i == 19);
      check("ovf_small_err", {31'b0, load_err2}, 32'd1);
      check("ovf_small_run", {31'b0, core_run2}, 32'd1);
      check("ovf_big_err", {31'b0, load_err}, 32'd0);
      check("ovf_big_run", {31'b0, core_run}, 32'd1);
      drain("ovf");

      // load_start in RUN with a simultaneous core write
      addr_d = 32'h100;
      wdata  = 32'hCAFE_F00D;
      wen    = 1'b1;
      pulse_load();
      wen    = 1'b0;
      check("abort_core_run", {31'b0, core_run}, 32'd0);
      check("abort_small_run", {31'b0, core_run2}, 32'd0);
      check("abort_err_cleared", {31'b0, load_err2}, 32'd0);
      send_byte(8'hEE, 1'b0);
      send_byte(8'hFF, 1'b1);
      drain("restart");
      read_check("restart_word1_kept", 32'h4, 32'h0807_0605);
      check("restart_small_word1", inst2, 32'h0807_0605);
      read_check("wr_with_abort", 32'h100, 32'hCAFE_F00D);
      @(negedge clk);

      // Asynchronous reset mid-load: complete word stays, partial is lost
      pulse_load();
      send_byte(8'h11, 1'b0);
      send_byte(8'h22, 1'b0);
      send_byte(8'h33, 1'b0);
      send_byte(8'h44, 1'b0);
      send_byte(8'h55, 1'b0);
      send_byte(8'h66, 1'b0);
      async_reset();
      core_write(32'h100, 32'h2222_2222);
      pulse_run();
      check("run_start_core_run", {31'b0, core_run}, 32'd1);
      drain("midreset");
      read_check("midreset_partial_lost", 32'h4, 32'h0807_0605);
      read_check("wen_in_idle_ignored", 32'h100, 32'hCAFE_F00D);
      @(negedge clk);

      // load_start and run_start together in IDLE: LOAD wins
      async_reset();
      load_start = 1'b1;
      run_start  = 1'b1;
      @(negedge clk);
      load_start = 1'b0;
      run_start  = 1'b0;
      tb_acc = '0;
      tb_k   = 0;
      tb_ptr = 0;
      check("both_load_ready", {31'b0, load_ready}, 32'd1);
      check("both_core_run", {31'b0, core_run}, 32'd0);
      check("both_state", {30'b0, dbg_state}, 32'd1);
      send_byte(8'h7F, 1'b1);
      check("both_final_run", {31'b0, core_run}, 32'd1);
      drain("both");

      // ---------------- report ----------------
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
